key_step_conditioner: RTL
=========================

// Module: key_step_conditioner
// PURPOSE
//  Front end for the board-level sequence-detector FSM. Turns the raw,
//   bouncing KEY[3] pushbutton into a clean one-cycle step strobe on CLOCK_50.
//  Captures SW[0] as the data bit for that step.
//  The downstream detector advances exactly once per accepted press and
//   consumes step/data_bit synchronously instead of clocking on a key edge.
// PARAMETERS
//  SYNC_STAGES      2          synchronizer depth for KEY3_n and SW0 (>=2)
//  DEBOUNCE_CYCLES  1_000_000  stable cycles required to accept a level change (20 ms @ 50 MHz)
//  CNT_W            20         debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  CLOCK_50    in   1  system clock, 50 MHz
//  KEY0        in   1  reset, asynchronous, active-low (pushbutton KEY[0])
//  KEY3_n      in   1  raw step pushbutton, active-low, asynchronous to CLOCK_50, bouncing
//  SW0         in   1  raw data switch, asynchronous to CLOCK_50
//  step        out  1  one-cycle strobe per accepted press
//  data_bit    out  1  SW0 value captured with the last step; held between steps
//  key_level   out  1  debounced key state, 1 = pressed
//  step_count  out  8  accepted presses since reset, wraps 255->0
// BEHAVIOUR
//  Reset: async on KEY0=0 (all flops).
//   - Outputs after reset: step=0, data_bit=0, key_level=0, step_count=0.
//   - Synchronizer flops reset to "released" (KEY3_n=1, SW0=0); counter=0.
//   - FSM resets to S_REL_CHK.
//  Sync: KEY3_n and SW0 each pass SYNC_STAGES flops. All logic uses synced values only.
//  FSM states (key_level=1 in S_HELD and S_REL_CHK):
//   - S_IDLE: synced key pressed -> S_PRESS_CHK, cnt=0.
//   - S_PRESS_CHK: pressed -> cnt++.
//       released before cnt reaches DEBOUNCE_CYCLES-1 -> S_IDLE, no step.
//       cnt==DEBOUNCE_CYCLES-1 and still pressed -> S_HELD.
//   - S_HELD: released -> S_REL_CHK, cnt=0.
//   - S_REL_CHK: released -> cnt++; cnt==DEBOUNCE_CYCLES-1 -> S_IDLE.
//       pressed again -> S_HELD, no new step (release bounce).
//  Step: step=1 for exactly the one cycle after the PRESS_CHK->HELD transition edge.
//   - On that same edge: data_bit <= synced SW0; step_count++.
//  Latency: raw press to step = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (bounce-free input).
//  Reset release: FSM starts in S_REL_CHK, so a key held through reset gives no step.
//   - A step requires a full release interval, then a full press interval.
//  Reset mid-press: all state dropped immediately; no step is ever partially emitted.
//  SW0 changes between steps: no effect on data_bit.
//  step_count rolls over silently; step itself is never suppressed.
//  Simultaneous events:
//   - KEY0 has priority over everything.
//   - Counter expiry and an input reversal in the same cycle: the reversal wins;
//     the level change is not accepted.
// STRUCTURE
//  automat_pkg (shared with the detector):
//   - state encodings S_IDLE/S_PRESS_CHK/S_HELD/S_REL_CHK as 2-bit localparams.
//   - DEBOUNCE_CYCLES_DEFAULT.
//   - SIM_DEBOUNCE_CYCLES = 4.
//  Sub-module: sync_ff (SYNC_STAGES-deep, reset-value parameter), one instance per raw input.
//  FSM, counter, and output registers stay in this module.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1. Clean press: hold KEY0=0, release, wait 6 clk.
//     Then KEY3_n=0 with SW0=1, held for 10 clk.
//     -> one step pulse 7 clk after press, data_bit=1, step_count=1.
//  2. Bounce: KEY3_n toggles every 2 clk for 12 clk, then stays low.
//     -> exactly one step, issued 7 clk after the final falling edge.
//  3. Release bounce: pressed and accepted, then KEY3_n 1,0,1 (1 clk each), then high.
//     -> no second step; key_level drops 7 clk after the final rise.
//  4. Held through reset: KEY3_n=0 while KEY0 deasserts, held for 20 clk.
//     -> no step, step_count=0.
//  5. Wrap: 256 clean presses with alternating SW0.
//     -> step_count 255->0; data_bit matches SW0 at each step.
//  6. Mid-operation reset: KEY0=0 at cnt=2 of S_PRESS_CHK.
//     -> all outputs 0 at once; no step after reset release.

Source files
------------

// File: rtl/automat_pkg.sv
// Shared definitions for the step conditioner and the sequence-detector FSM:
// debouncer state encodings and debounce interval constants.
package automat_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } deb_state_e;

  // 20 ms at 50 MHz for the board; simulation uses a tiny interval.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  localparam int STEP_COUNT_W = 8;

endpackage : automat_pkg

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for one asynchronous input bit.
// RST_VAL lets each instance reset to the input's inactive level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/key_step_conditioner.sv
// Debounces the raw KEY[3] pushbutton into a one-cycle step strobe on CLOCK_50
// and captures SW[0] as the data bit for each accepted press.
module key_step_conditioner
  import automat_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       KEY3_n,
  input  logic       SW0,
  output logic       step,
  output logic       data_bit,
  output logic       key_level,
  output logic [7:0] step_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       key_sync_n;
  logic       sw_sync;
  logic       pressed;
  deb_state_e state;
  logic [CNT_W-1:0] cnt;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_key (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .d     (KEY3_n),
    .q     (key_sync_n)
  );

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_sw (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .d     (SW0),
    .q     (sw_sync)
  );

  assign pressed = ~key_sync_n;

  // Starting in S_REL_CHK means a key held through reset must first be seen
  // released for a full interval before any press can be accepted. key_level
  // only rises once a pressed level has actually been observed.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= S_REL_CHK;
      cnt        <= '0;
      step       <= 1'b0;
      data_bit   <= 1'b0;
      key_level  <= 1'b0;
      step_count <= '0;
    end else begin
      step <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pressed) begin
            state <= S_PRESS_CHK;
            cnt   <= '0;
          end
        end
        S_PRESS_CHK: begin
          // A reversal wins over expiry in the same cycle.
          if (!pressed) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state      <= S_HELD;
            key_level  <= 1'b1;
            step       <= 1'b1;
            data_bit   <= sw_sync;
            step_count <= step_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HELD: begin
          key_level <= 1'b1;
          if (!pressed) begin
            state <= S_REL_CHK;
            cnt   <= '0;
          end
        end
        S_REL_CHK: begin
          // Pressing again here is release bounce: back to held, no new step.
          if (pressed) begin
            state     <= S_HELD;
            key_level <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state     <= S_IDLE;
            key_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= S_IDLE;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule : key_step_conditioner
